// File: rtl/dr_sync_rx.sv
// Async completion-token receiver: sync done_in, 4-phase ack, queue words in a DEPTH-entry FIFO.
// Push/ack SYNC_STAGES edges after done_in is first sampled high; a full FIFO withholds ack (no drops).
module dr_sync_rx #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ack_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_ack;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [DATA_W-1:0]       r_mem [DEPTH];

    logic w_done_s;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_done_s = r_sync[SYNC_STAGES-1];
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_push   = (r_state == S_IDLE) && w_done_s && !w_full;
    assign w_pop    = (r_count != '0) && out_ready;

    assign ack_out    = r_ack;
    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_rd_ptr];
    assign fifo_count = r_count;

    // Reset to all-ones: a token possibly in flight at reset is never captured twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], done_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_ack <= 1'b0;
                    if (!w_done_s) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (w_push) begin
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!w_done_s) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

endmodule

// File: doc/dr_sync_rx.md
# dr_sync_rx

Clocked receiver for completion-detected asynchronous tokens. It consumes the single-rail completion signal produced by the upstream C-element completion tree, together with the bundled data word it qualifies. It closes the 4-phase return-to-zero handshake with a registered acknowledge, and queues captured words into a small FIFO with a valid/ready interface for the synchronous pipeline downstream. Backpressure is applied by withholding the acknowledge, so no token is ever dropped.

## Interface
- DATA_W, 8, width of the bundled data word.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flip-flops in the `done_in` synchronizer; minimum 2.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts on clock).
- done_in  in  1  asynchronous completion from the C-element tree; high = token present, low = spacer.
- data_in  in  DATA_W  bundled data; guaranteed stable from `done_in` rise until `ack_out` rises.
- ack_out  out  1  4-phase acknowledge to the upstream stage; registered, glitch-free.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts head word.
- out_data  out  DATA_W  FIFO head word; valid only when out_valid=1.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Synchronizer: `done_in` passes through a SYNC_STAGES flop chain to give `done_s`. The chain resets to all-ones (pessimistic: a token is assumed present).
- The FSM has three states.
- INIT, the reset state: ack_out=0. Go to IDLE on the first cycle with done_s=0. This prevents a token that was in flight at reset from being captured twice.
- IDLE: ack_out=0. If done_s=1 and fifo_count<DEPTH: push data_in, set ack_out=1, go to ACK. If done_s=1 and the FIFO is full: stay in IDLE with no push. The upstream stalls with done_in held.
- ACK: ack_out=1. If done_s=0: set ack_out=0 and go to IDLE. While in ACK, done_s=1 causes no further push.
- FIFO: a circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. The occupancy counter is fifo_count.
- Pop occurs when out_valid & out_ready.
- Push is qualified by full as registered at the start of the cycle. There is no same-cycle pop-frees-slot bypass: a push into a full FIFO waits one cycle even if a pop occurs.
- Simultaneous push and pop (FIFO not full, not empty): fifo_count is unchanged and both pointers advance.
- Pop with out_valid=0 is ignored. out_data is registered-read of mem[rd_ptr], i.e. memory indexed by a registered pointer. It is undefined when the FIFO is empty.
- Reset values: ack_out=0, out_valid=0, fifo_count=0, pointers=0, FSM=INIT. FIFO contents are not reset.
- Reset mid-operation: all queued words are discarded. If done_in is high at reset release, the FSM holds in INIT until done_in returns low. The upstream is responsible for its own reset to spacer.

## Timing
- Capture latency: let edge E1 be the first rising edge that samples done_in=1. The push and ack_out=1 occur at edge E1+SYNC_STAGES. With the default SYNC_STAGES=2, this is the 3rd edge.
- out_valid rises at the same edge as the push (empty→1). out_data is valid in that same cycle.
- Release latency: ack_out falls SYNC_STAGES edges after the first edge that samples done_in=0.
- Throughput: at most one token per 2·(SYNC_STAGES+1) cycles, plus upstream delay.
- Full stall: ack_out rises at the first edge where fifo_count<DEPTH and done_s=1. This is one cycle after the pop that frees the slot.
- done_in must obey the 4-phase protocol. A done_in pulse shorter than SYNC_STAGES+1 cycles is a protocol violation, and its behaviour is unspecified.

## Test plan
- Reset with done_in=0, then token 0xA5 → INIT→IDLE after 2 cycles; ack_out=1 and out_valid=1 with out_data=0xA5 at the 3rd edge after done_in rises; ack_out=0 3rd edge after done_in falls.
- out_ready=0, send 5 tokens 0x01..0x05 (DEPTH=4) → fifo_count reaches 4; 5th token: ack_out stays 0; assert out_ready for one cycle → pops 0x01, ack_out rises next edge, 0x05 queued, fifo_count=4.
- out_ready=1 continuously, 16 tokens 0x00..0x0F → output order exact; pointer wrap exercised 4 times; fifo_count never exceeds 1.
- Push and pop in the same cycle with fifo_count=2 → fifo_count remains 2, head advances, no data corruption.
- rst asserted while in ACK with 3 words queued and done_in=1 → ack_out=0, out_valid=0, fifo_count=0 immediately; after release, no capture until done_in goes low and then high with a new token.
- done_in held high through reset release → FSM stays in INIT, ack_out=0 indefinitely; drop done_in, then send 0x3C → single capture of 0x3C only.
